// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, delay-slot redirect, inst-SRAM handshake, IF/ID register
// Optional feature: define IF_ADEL_EN to report misaligned fetch addresses on o_adel instead of masking them.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] FLUSH_PC = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_stall,
    input  logic        id_valid,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jrpc,
    input  logic [31:0] jpc,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
`ifdef IF_ADEL_EN
    ,
    output logic        o_adel
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] redirect_target;
    logic [31:0] hold_inst;
    logic        redirect_pending;
    logic        drop;
    logic        drop_nx;

    logic        redirect_evt;
    logic [31:0] sel_target;
    logic [31:0] next_pc;
    logic [31:0] load_inst;
    logic        load_ifid;
    logic        adel_load;
    logic        buf_load;
    logic        pc_misaligned;

`ifdef IF_ADEL_EN
    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign inst_addr     = pc;
`else
    assign pc_misaligned = 1'b0;
    assign inst_addr     = {pc[31:2], 2'b00};
`endif

    // A misaligned pc never reaches memory; it is retired through IF/ID instead.
    assign inst_req = !reset && (state == S_REQ) && !pc_misaligned;

    always_comb begin
        sel_target = bpc;
        case (pcsource)
            2'b01:   sel_target = bpc;
            2'b10:   sel_target = jrpc;
            2'b11:   sel_target = jpc;
            default: sel_target = bpc;
        endcase
    end

    assign redirect_evt = id_valid && !id_stall && (pcsource != 2'b00);

    // A redirect seen in the same cycle as the pc load bypasses redirect_target.
    assign next_pc = redirect_evt     ? sel_target :
                     redirect_pending ? redirect_target :
                                        pc + 32'd4;

    always_comb begin
        state_nx  = state;
        drop_nx   = drop;
        load_ifid = 1'b0;
        adel_load = 1'b0;
        buf_load  = 1'b0;
        load_inst = inst_rdata;
        if (flush) begin
            case (state)
                S_REQ: begin
                    if (inst_req && inst_addr_ok) begin
                        state_nx = S_WAIT;
                        drop_nx  = 1'b1;
                    end else begin
                        state_nx = S_REQ;
                    end
                end
                S_WAIT: begin
                    // Data returning this very cycle is the outstanding word; nothing is left to drop.
                    if (inst_data_ok) begin
                        state_nx = S_REQ;
                        drop_nx  = 1'b0;
                    end else begin
                        state_nx = S_WAIT;
                        drop_nx  = 1'b1;
                    end
                end
                S_HOLD:  state_nx = S_REQ;
                default: state_nx = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (pc_misaligned) begin
                        if (!id_stall) begin
                            load_ifid = 1'b1;
                            adel_load = 1'b1;
                            load_inst = 32'h0;
                        end
                    end else if (inst_req && inst_addr_ok) begin
                        state_nx = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (drop) begin
                            drop_nx  = 1'b0;
                            state_nx = S_REQ;
                        end else if (!id_stall) begin
                            load_ifid = 1'b1;
                            state_nx  = S_REQ;
                        end else begin
                            buf_load = 1'b1;
                            state_nx = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        load_ifid = 1'b1;
                        load_inst = hold_inst;
                        state_nx  = S_REQ;
                    end
                end
                default: state_nx = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_REQ;
            drop             <= 1'b0;
            pc               <= RESET_PC;
            redirect_pending <= 1'b0;
            redirect_target  <= 32'h0;
            hold_inst        <= 32'h0;
        end else begin
            state <= state_nx;
            drop  <= drop_nx;
            if (buf_load) begin
                hold_inst <= inst_rdata;
            end
            if (flush) begin
                pc               <= FLUSH_PC;
                redirect_pending <= 1'b0;
            end else if (load_ifid) begin
                pc               <= next_pc;
                redirect_pending <= 1'b0;
            end else if (redirect_evt) begin
                redirect_pending <= 1'b1;
                redirect_target  <= sel_target;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_pc    <= 32'h0;
            o_inst  <= 32'h0;
            o_valid <= 1'b0;
        end else if (flush) begin
            o_valid <= 1'b0;
        end else if (!id_stall) begin
            o_valid <= load_ifid;
            if (load_ifid) begin
                o_pc   <= pc;
                o_inst <= load_inst;
            end
        end
    end

`ifdef IF_ADEL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_adel <= 1'b0;
        end else if (flush) begin
            o_adel <= 1'b0;
        end else if (!id_stall) begin
            o_adel <= adel_load;
        end
    end
`else
    logic unused_adel;
    assign unused_adel = adel_load;
`endif

endmodule
